hilo_div: RTL

HILO_DIV -- requirements
Module: hilo_div

---
 rtl/hilo_div_pkg.sv | 26 ++
 rtl/hilo_div_if.sv | 25 ++
 rtl/hilo_div.sv | 96 +++++++++
 3 files changed

// File: rtl/hilo_div_pkg.sv
// Shared defines for the HI/LO divider: FSM encoding, iteration count and
// the EX/MEM/WB forwarding-bus field positions for the HI/LO write fields.
package hilo_div_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_t;

    localparam int unsigned DIV_CYCLES_DEF = 32;

    localparam int unsigned FWD_W      = 104;
    localparam int unsigned FWD_HI_WE  = 103;
    localparam int unsigned FWD_HI_MSB = 102;
    localparam int unsigned FWD_HI_LSB = 71;
    localparam int unsigned FWD_LO_WE  = 70;
    localparam int unsigned FWD_LO_MSB = 69;
    localparam int unsigned FWD_LO_LSB = 38;

    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic n);
        return n ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/hilo_div_if.sv
// EX-stage <-> divider signal bundle; the divider keeps flat ports, so this
// bundle is what the EX stage (or a bench) wires onto them.
interface hilo_div_if;
    logic        start;
    logic        signed_op;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        annul;
    logic        stall;
    logic        ready;
    logic        hi_we;
    logic [31:0] hi;
    logic        lo_we;
    logic [31:0] lo;

    modport master (
        output start, signed_op, opdata1, opdata2, annul,
        input  stall, ready, hi_we, hi, lo_we, lo
    );

    modport slave (
        input  start, signed_op, opdata1, opdata2, annul,
        output stall, ready, hi_we, hi, lo_we, lo
    );
endinterface

// File: rtl/hilo_div.sv
// Multi-cycle restoring divider for DIV/DIVU producing HI (remainder) and
// LO (quotient), one quotient bit per cycle, with flush and pipeline stall.
module hilo_div
    import hilo_div_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        annul_i,
    output logic        stall_o,
    output logic        ready_o,
    output logic        w_hi_we_o,
    output logic [31:0] w_hi_o,
    output logic        w_lo_we_o,
    output logic [31:0] w_lo_o
);

    div_state_t  state, state_next;
    logic [5:0]  cnt;
    logic [64:0] pr, pr_next;
    logic [33:0] diff;
    logic [31:0] divisor, raw_dvd, mag1, mag2;
    logic        neg_q, neg_r, accept, last;

    assign accept = (state == DIV_IDLE) && start_i && !annul_i;
    assign last   = (cnt == 6'(DIV_CYCLES - 1));
    assign mag1   = neg_if(opdata1_i, signed_i & opdata1_i[31]);
    assign mag2   = neg_if(opdata2_i, signed_i & opdata2_i[31]);

    // pr = {remainder[64:33], unconsumed dividend bits, quotient bits};
    // the minuend uses all 33 top bits so divisors above 2^31 stay exact.
    always_comb begin
        diff    = {1'b0, pr[64:32]} - {2'b00, divisor};
        pr_next = diff[33] ? {pr[63:0], 1'b0} : {diff[31:0], pr[31:0], 1'b1};
    end

    always_comb begin
        state_next = state;
        case (state)
            DIV_IDLE:    if (accept) state_next = (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
            DIV_BY_ZERO: state_next = annul_i ? DIV_IDLE : DIV_END;
            DIV_ON:      state_next = annul_i ? DIV_IDLE : (last ? DIV_END : DIV_ON);
            DIV_END:     state_next = DIV_IDLE;
            default:     state_next = DIV_IDLE;
        endcase
    end

    always_comb begin
        stall_o   = accept || (state == DIV_ON) || (state == DIV_BY_ZERO);
        ready_o   = (state == DIV_END);
        w_hi_we_o = (state == DIV_END);
        w_lo_we_o = (state == DIV_END);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= DIV_IDLE;
        else         state <= state_next;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt     <= '0;
            pr      <= '0;
            divisor <= '0;
            raw_dvd <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            w_hi_o  <= '0;
            w_lo_o  <= '0;
        end else if (accept) begin
            cnt     <= '0;
            pr      <= {32'd0, mag1, 1'b0};
            divisor <= mag2;
            raw_dvd <= opdata1_i;
            neg_q   <= signed_i & (opdata1_i[31] ^ opdata2_i[31]);
            neg_r   <= signed_i & opdata1_i[31];
        end else if (state == DIV_ON && !annul_i) begin
            pr  <= pr_next;
            cnt <= cnt + 6'd1;
            // Result is fixed up from the final step so it is valid during END.
            if (last) begin
                w_lo_o <= neg_if(pr_next[31:0], neg_q);
                w_hi_o <= neg_if(pr_next[64:33], neg_r);
            end
        end else if (state == DIV_BY_ZERO && !annul_i) begin
            w_lo_o <= '1;
            w_hi_o <= raw_dvd;
        end
    end

endmodule
